// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encoding and
// default timing derivation.
package key_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    localparam int CLK_HZ_DEFAULT      = 50000000;
    localparam int DEBOUNCE_MS_DEFAULT = 20;

    // Qualification length in clock cycles for a given clock and debounce time.
    function automatic int stable_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key input and conditioned outputs of the debouncer; slave is the debouncer
// side, master is whoever drives the raw key and consumes the strobes.
interface key_debouncer_if;

    logic KEY_3;
    logic filtered;
    logic press_pulse;
    logic release_pulse;

    modport master (
        output KEY_3,
        input  filtered,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  KEY_3,
        output filtered,
        output press_pulse,
        output release_pulse
    );

endinterface

// File: rtl/key_debouncer_two_flop_sync.sv
// Plain two-flop synchroniser for a single asynchronous level, reset to 0.
// Shared with the other switch inputs on the board.
module two_flop_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic q1_q;
    logic q2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q1_q <= d_i;
            q2_q <= q1_q;
        end
    end

    assign q_o = q2_q;

endmodule

// File: rtl/key_debouncer.sv
// Pushbutton conditioner: synchronises active-low KEY_3, qualifies each new
// level for STABLE_CYCLES cycles, and emits a clean level plus edge strobes.
//
// state           | meaning
// ----------------+---------------------------------------------------
// ST_IDLE         | key accepted as released, watching for a press
// ST_WAIT_PRESS   | press seen, counting stable cycles before accepting
// ST_PRESSED      | key accepted as pressed, watching for a release
// ST_WAIT_RELEASE | release seen, counting stable cycles before accepting
module key_debouncer
    import key_pkg::*;
#(
    parameter int CLK_HZ        = CLK_HZ_DEFAULT,
    parameter int STABLE_CYCLES = stable_cycles(CLK_HZ, DEBOUNCE_MS_DEFAULT)
) (
    input  logic            PIN_Y2,
    input  logic            SW17,
    key_debouncer_if.slave  key_if
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic             key_pressed_raw;
    logic             s;
    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             filtered_q, filtered_d;
    logic             press_q,    press_d;
    logic             release_q,  release_d;

    assign key_pressed_raw = ~key_if.KEY_3;

    two_flop_sync u_sync (
        .clk_i (PIN_Y2),
        .rst_i (SW17),
        .d_i   (key_pressed_raw),
        .q_o   (s)
    );

    // Any sample of the old level drops back to the settled state with cnt
    // cleared, so qualification always restarts from scratch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        filtered_d = filtered_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_WAIT_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_WAIT_PRESS: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d    = ST_PRESSED;
                    filtered_d = 1'b1;
                    press_d    = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_WAIT_RELEASE;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_WAIT_RELEASE: begin
                if (s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d    = ST_IDLE;
                    filtered_d = 1'b0;
                    release_d  = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge PIN_Y2) begin
        if (SW17) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            filtered_q <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            filtered_q <= filtered_d;
            press_q    <= press_d;
            release_q  <= release_d;
        end
    end

    assign key_if.filtered      = filtered_q;
    assign key_if.press_pulse   = press_q;
    assign key_if.release_pulse = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer with STABLE_CYCLES=4: stimulus queues the
// expected strobe and its cycle, a negedge monitor pops and compares.
module tb_key_debouncer;
    import key_pkg::*;

    localparam int STABLE = 4;
    // KEY_3 changed just after edge c is captured at c+1; strobe follows STABLE+2 edges later.
    localparam int LAT = STABLE + 3;

    typedef struct {
        bit is_press;
        int cycle;
    } exp_t;

    logic PIN_Y2 = 1'b0;
    logic SW17;
    logic rst_prev = 1'b1;
    logic prev_f = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];

    key_debouncer_if kif();

    key_debouncer #(.STABLE_CYCLES(STABLE)) dut (
        .PIN_Y2 (PIN_Y2),
        .SW17   (SW17),
        .key_if (kif.slave)
    );

    always #10 PIN_Y2 = ~PIN_Y2;

    always @(posedge PIN_Y2) begin
        cyc      <= cyc + 1;
        rst_prev <= SW17;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge PIN_Y2);
        #1;
    endtask

    task automatic expect_ev(input bit is_press, input int at);
        exp_t e;
        e.is_press = is_press;
        e.cycle    = at;
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge PIN_Y2) begin
        exp_t e;
        if (rst_prev) begin
            check("rst_filtered", int'(kif.filtered), 0);
            check("rst_press", int'(kif.press_pulse), 0);
            check("rst_release", int'(kif.release_pulse), 0);
        end else begin
            if (kif.press_pulse || kif.release_pulse) begin
                check("strobe_exclusive", int'(kif.press_pulse & kif.release_pulse), 0);
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_strobe at cycle %0d: got press=%0b release=%0b, expected none",
                             cyc, kif.press_pulse, kif.release_pulse);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind_press", int'(kif.press_pulse), int'(e.is_press));
                    check("strobe_cycle", cyc, e.cycle);
                    check("filtered_at_strobe", int'(kif.filtered), int'(e.is_press));
                end
            end else if (kif.filtered !== prev_f) begin
                checks++;
                fails++;
                $display("FAIL filtered_without_strobe at cycle %0d: got %0b, expected %0b",
                         cyc, kif.filtered, prev_f);
            end
            if (sb.size() > 0 && sb[0].cycle < cyc) begin
                checks++;
                fails++;
                $display("FAIL missed_strobe at cycle %0d: got none, expected press=%0b at cycle %0d",
                         cyc, sb[0].is_press, sb[0].cycle);
                void'(sb.pop_front());
            end
            checks++;
            if (int'(dut.cnt_q) > STABLE) begin
                fails++;
                $display("FAIL cnt_bound at cycle %0d: got %0d, expected <= %0d", cyc, dut.cnt_q, STABLE);
            end
        end
        prev_f = kif.filtered;
    end

    initial begin
        SW17      = 1'b1;
        kif.KEY_3 = 1'b0;

        // Reset with key held, then requalification from IDLE.
        wait_cyc(3);
        SW17 = 1'b0;
        expect_ev(1'b1, cyc + LAT);
        wait_cyc(12);
        check("reset_then_held_filtered", int'(kif.filtered), 1);
        kif.KEY_3 = 1'b1;
        expect_ev(1'b0, cyc + LAT);
        wait_cyc(12);
        check("first_release_filtered", int'(kif.filtered), 0);

        // Clean press and release.
        kif.KEY_3 = 1'b0;
        expect_ev(1'b1, cyc + LAT);
        wait_cyc(20);
        check("clean_press_filtered", int'(kif.filtered), 1);
        kif.KEY_3 = 1'b1;
        expect_ev(1'b0, cyc + LAT);
        wait_cyc(12);
        check("clean_release_filtered", int'(kif.filtered), 0);

        // Bounce rejection: 3 low, 1 high, 3 low, then high.
        kif.KEY_3 = 1'b0;
        wait_cyc(3);
        kif.KEY_3 = 1'b1;
        wait_cyc(1);
        kif.KEY_3 = 1'b0;
        wait_cyc(3);
        kif.KEY_3 = 1'b1;
        wait_cyc(12);
        check("bounce_filtered", int'(kif.filtered), 0);
        check("bounce_state_idle", int'(dut.state_q), int'(ST_IDLE));

        // Two-cycle glitch, then steady low.
        kif.KEY_3 = 1'b0;
        wait_cyc(2);
        kif.KEY_3 = 1'b1;
        wait_cyc(1);
        kif.KEY_3 = 1'b0;
        expect_ev(1'b1, cyc + LAT);
        wait_cyc(15);
        check("settle_filtered", int'(kif.filtered), 1);
        kif.KEY_3 = 1'b1;
        expect_ev(1'b0, cyc + LAT);
        wait_cyc(12);

        // Reset pulsed mid-qualification (at the edge where cnt==3).
        kif.KEY_3 = 1'b0;
        wait_cyc(5);
        SW17 = 1'b1;
        wait_cyc(1);
        SW17 = 1'b0;
        expect_ev(1'b1, cyc + LAT);
        wait_cyc(12);
        check("midreset_filtered", int'(kif.filtered), 1);
        kif.KEY_3 = 1'b1;
        expect_ev(1'b0, cyc + LAT);
        wait_cyc(12);

        // Long hold.
        kif.KEY_3 = 1'b0;
        expect_ev(1'b1, cyc + LAT);
        for (int i = 0; i < 10; i++) begin
            wait_cyc(100);
            check("long_hold_filtered", int'(kif.filtered), 1);
        end
        kif.KEY_3 = 1'b1;
        expect_ev(1'b0, cyc + LAT);
        wait_cyc(12);
        check("long_release_filtered", int'(kif.filtered), 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
